// File: rtl/iir_feed_pkg.sv
// rtl/iir_feed_pkg.sv - shared state encoding and default widths for the IIR sample feeder
package iir_feed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } feed_state_t;

  localparam int DEF_DW = 4;
  localparam int DEF_AW = 4;
  localparam int DEF_CW = 16;

endpackage

// File: rtl/iir_sync_fifo.sv
// rtl/iir_sync_fifo.sv - small synchronous FIFO, no bypass, registered occupancy
module iir_sync_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array carries no reset; validity is tracked by level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/iir_sample_feeder.sv
// rtl/iir_sample_feeder.sv - paced sample/coefficient feeder for the IIR; IIR_SAMPLE_FEEDER_UNDERRUN_CNT_EN adds underrun_cnt
module iir_sample_feeder
  import iir_feed_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int DEPTH     = 8,
  parameter int CW        = DEF_CW,
  parameter int PRIME_LVL = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [CW-1:0]           rate_div,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_data,
  input  logic                    coef_we,
  input  logic [AW-1:0]           coef_din,
  output logic [DW-1:0]           x_out,
  output logic [AW-1:0]           a_out,
  output logic                    x_stb,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    busy
`ifdef IIR_SAMPLE_FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [7:0]              underrun_cnt
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;

  feed_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] shadow;
  logic [DW-1:0] head;
  logic          full, empty;
  logic          push, tick, pop, underrun;

  // in_ready is held low while reset is asserted, otherwise it reflects the registered level.
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  assign tick     = (state == RUN) && enable && (cnt == rate_div);
  assign pop      = tick && !empty;
  assign underrun = tick && empty;
  assign busy     = (state != IDLE);

  iir_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  // Next state and divider: the counter only runs in RUN and restarts at 0 on every tick or state change.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE:    if (enable) state_nxt = PRIME;
      PRIME: begin
        if (!enable)                             state_nxt = IDLE;
        else if (fifo_level >= LW'(PRIME_LVL))   state_nxt = RUN;
      end
      RUN: begin
        if (!enable)       state_nxt = IDLE;
        else if (underrun) state_nxt = PRIME;
        if (enable && !tick) cnt_nxt = cnt + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and divider counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Coefficient shadow and output registers; a_out only moves together with a strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
      x_out  <= '0;
      a_out  <= '0;
      x_stb  <= 1'b0;
    end else begin
      if (coef_we) shadow <= coef_din;
      x_stb <= pop;
      if (pop) begin
        x_out <= head;
        a_out <= shadow;
      end
    end
  end

`ifdef IIR_SAMPLE_FEEDER_UNDERRUN_CNT_EN
  // Saturating count of ticks that found the FIFO empty; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)                             underrun_cnt <= '0;
    else if (underrun && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_iir_sample_feeder.sv
// tb/tb_iir_sample_feeder.sv - scoreboard bench for iir_sample_feeder; honours IIR_SAMPLE_FEEDER_UNDERRUN_CNT_EN
module tb_iir_sample_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] rate_div;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        coef_we;
  logic [3:0]  coef_din;
  logic [3:0]  x_out;
  logic [3:0]  a_out;
  logic        x_stb;
  logic [3:0]  fifo_level;
  logic        busy;
`ifdef IIR_SAMPLE_FEEDER_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  iir_sample_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .rate_div   (rate_div),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .coef_we    (coef_we),
    .coef_din   (coef_din),
    .x_out      (x_out),
    .a_out      (a_out),
    .x_stb      (x_stb),
    .fifo_level (fifo_level),
    .busy       (busy)
`ifdef IIR_SAMPLE_FEEDER_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int a;
    int c;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_stb(input int x, input int a, input int c);
    exp_t e;
    e.x = x; e.a = a; e.c = c;
    sb.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest expected delivery, including its cycle.
  always @(negedge clk) begin
    if (rst_n && x_stb) begin
      if (sb.size() == 0) begin
        chk("unexpected_stb", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("stb_x", int'(x_out), e.x);
        chk("stb_a", int'(a_out), e.a);
        chk("stb_cycle", cyc, e.c);
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input int v);
    in_valid = 1'b1;
    in_data  = 4'(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic write_coef(input int v);
    coef_we  = 1'b1;
    coef_din = 4'(v);
    @(negedge clk);
    coef_we  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, f, g;
    rst_n = 1'b0; enable = 1'b0; rate_div = '0;
    in_valid = 1'b0; in_data = '0; coef_we = 1'b0; coef_din = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("in_ready_in_reset", int'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_x_out", int'(x_out), 0);
    chk("rst_a_out", int'(a_out), 0);
    chk("rst_x_stb", int'(x_stb), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Idle pushes: stored but never delivered
    push(3); push(5); push(7);
    repeat (3) @(negedge clk);
    chk("idle_level", int'(fifo_level), 3);
    chk("idle_busy", int'(busy), 0);
    do_reset();
    @(negedge clk);
    chk("reset_discards", int'(fifo_level), 0);

    // Prime, pace (rate_div=3) and coefficient timing
    write_coef(6);
    push(1); push(2); push(3); push(4);
    rate_div = 16'd3;
    enable   = 1'b1;
    e = cyc;
    expect_stb(1, 6,  e + 6);
    expect_stb(2, 10, e + 10);
    expect_stb(3, 10, e + 14);
    expect_stb(4, 12, e + 18);
    goto(e + 7);
    write_coef(10);
    goto(e + 9);
    chk("a_out_holds_between_stb", int'(a_out), 6);
    goto(e + 13);
    write_coef(12);
    goto(e + 23);
    chk("pace_underrun_busy", int'(busy), 1);
    chk("pace_underrun_x_hold", int'(x_out), 4);
    chk("pace_underrun_a_hold", int'(a_out), 12);
    chk("pace_underrun_level", int'(fifo_level), 0);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_to_idle", int'(busy), 0);
    do_reset();

    // Full FIFO, push refused while popping, back-to-back strobes, underrun
    write_coef(5);
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 1);
      chk("full_in_ready", int'(in_ready), (i < 8) ? 1 : 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("full_level", int'(fifo_level), 8);
    rate_div = 16'd0;
    in_valid = 1'b1;
    in_data  = 4'd14;
    enable   = 1'b1;
    f = cyc;
    for (int k = 0; k < 8; k++) expect_stb(k + 1, 5, f + 3 + k);
    goto(f + 3);
    chk("full_refuses_push_on_pop", int'(fifo_level), 7);
    in_valid = 1'b0;
    goto(f + 12);
    chk("ur_busy_prime", int'(busy), 1);
    chk("ur_no_stb", int'(x_stb), 0);
    chk("ur_x_hold", int'(x_out), 8);
    chk("ur_level", int'(fifo_level), 0);
`ifdef IIR_SAMPLE_FEEDER_UNDERRUN_CNT_EN
    chk("ur_cnt", int'(underrun_cnt), 1);
`endif
    enable = 1'b0;
    @(negedge clk);

    // Reset in the middle of RUN with five samples queued
    push(2); push(4); push(6); push(8); push(10);
    rate_div = 16'd100;
    enable   = 1'b1;
    g = cyc;
    goto(g + 6);
    chk("midrun_busy", int'(busy), 1);
    chk("midrun_level", int'(fifo_level), 5);
    rst_n  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_level", int'(fifo_level), 0);
    chk("midrst_x_out", int'(x_out), 0);
    chk("midrst_a_out", int'(a_out), 0);
    chk("midrst_busy", int'(busy), 0);
`ifdef IIR_SAMPLE_FEEDER_UNDERRUN_CNT_EN
    chk("midrst_ur_cnt", int'(underrun_cnt), 0);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
